// File: rtl/ex_result_pkg.sv
// Shared definitions for the execute-stage result path: funct3 encodings,
// skid-buffer state encoding and datapath width defaults.
package ex_result_pkg;

  localparam int XLEN_DEFAULT       = 32;
  localparam int REG_ADDR_W_DEFAULT = 5;

  // Integer-op funct3 encodings; SRL and SRA share F3_SRL.
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } ex_state_e;

endpackage

// File: rtl/ex_result_mux.sv
// Combinational ALU result select by funct3. The set unit only produces a
// meaningful bit 0, so its upper bits are forced to zero here.
module ex_result_mux
  import ex_result_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] add_res_i,
  input  logic [XLEN-1:0] set_res_i,
  input  logic [XLEN-1:0] logic_res_i,
  input  logic [XLEN-1:0] shift_res_i,
  output logic [XLEN-1:0] result_o
);

  logic unused_set_hi;
  assign unused_set_hi = ^set_res_i[XLEN-1:1];

  always_comb begin
    result_o = logic_res_i;
    case (funct3_i)
      F3_ADD:          result_o = add_res_i;
      F3_SLL, F3_SRL:  result_o = shift_res_i;
      F3_SLT, F3_SLTU: result_o = {{(XLEN-1){1'b0}}, set_res_i[0]};
      default:         result_o = logic_res_i;
    endcase
  end

endmodule

// File: rtl/ex_result_stage.sv
// EX/MEM boundary: selects the ALU result, holds it in a 2-entry skid buffer
// (head drives MEM and the forwarding path, skid absorbs one MEM stall).
module ex_result_stage
  import ex_result_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic                  Flush,
  input  logic                  In_Valid,
  output logic                  In_Ready,
  input  logic [2:0]            Funct3,
  input  logic [REG_ADDR_W-1:0] Rd_Addr,
  input  logic                  Reg_Wr,
  input  logic [XLEN-1:0]       Add_Res,
  input  logic [XLEN-1:0]       Set_Res,
  input  logic [XLEN-1:0]       Logic_Res,
  input  logic [XLEN-1:0]       Shift_Res,
  output logic                  Out_Valid,
  input  logic                  Out_Ready,
  output logic [XLEN-1:0]       Out_Result,
  output logic [REG_ADDR_W-1:0] Out_Rd,
  output logic                  Out_Reg_Wr,
  output logic                  Fwd_Valid,
  output logic [REG_ADDR_W-1:0] Fwd_Rd,
  output logic [XLEN-1:0]       Fwd_Data,
  output ex_state_e             Dbg_State
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and a raised valid with its data
  // stays stable until it is transferred (or flushed).

  logic [XLEN-1:0]       new_result;
  logic                  new_wr;

  ex_state_e             state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic [XLEN-1:0]       head_result_q, head_result_d;
  logic [REG_ADDR_W-1:0] head_rd_q, head_rd_d;
  logic                  head_wr_q, head_wr_d;
  logic [XLEN-1:0]       skid_result_q, skid_result_d;
  logic [REG_ADDR_W-1:0] skid_rd_q, skid_rd_d;
  logic                  skid_wr_q, skid_wr_d;

  logic                  out_valid;
  logic                  accept;
  logic                  pop;

  ex_result_mux #(.XLEN(XLEN)) u_mux (
    .funct3_i    (Funct3),
    .add_res_i   (Add_Res),
    .set_res_i   (Set_Res),
    .logic_res_i (Logic_Res),
    .shift_res_i (Shift_Res),
    .result_o    (new_result)
  );

  // x0 is hardwired zero: never let an entry claim to write it.
  assign new_wr    = Reg_Wr & (Rd_Addr != '0);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = In_Valid & in_ready_q;
  assign pop       = out_valid & Out_Ready;

  always_comb begin
    state_d       = state_q;
    head_result_d = head_result_q;
    head_rd_d     = head_rd_q;
    head_wr_d     = head_wr_q;
    skid_result_d = skid_result_q;
    skid_rd_d     = skid_rd_q;
    skid_wr_d     = skid_wr_q;
    if (Flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            head_result_d = new_result;
            head_rd_d     = Rd_Addr;
            head_wr_d     = new_wr;
            state_d       = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            head_result_d = new_result;
            head_rd_d     = Rd_Addr;
            head_wr_d     = new_wr;
          end else if (accept) begin
            skid_result_d = new_result;
            skid_rd_d     = Rd_Addr;
            skid_wr_d     = new_wr;
            state_d       = ST_TWO;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // In_Ready is low here, so only a pop can move the buffer.
          if (pop) begin
            head_result_d = skid_result_q;
            head_rd_d     = skid_rd_q;
            head_wr_d     = skid_wr_q;
            state_d       = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_EMPTY;
      in_ready_q    <= 1'b1;
      head_result_q <= '0;
      head_rd_q     <= '0;
      head_wr_q     <= 1'b0;
      skid_result_q <= '0;
      skid_rd_q     <= '0;
      skid_wr_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      head_result_q <= head_result_d;
      head_rd_q     <= head_rd_d;
      head_wr_q     <= head_wr_d;
      skid_result_q <= skid_result_d;
      skid_rd_q     <= skid_rd_d;
      skid_wr_q     <= skid_wr_d;
    end
  end

  assign In_Ready   = in_ready_q;
  assign Out_Valid  = out_valid;
  assign Out_Result = head_result_q;
  assign Out_Rd     = head_rd_q;
  assign Out_Reg_Wr = head_wr_q;
  assign Fwd_Valid  = out_valid & head_wr_q & (head_rd_q != '0);
  assign Fwd_Rd     = head_rd_q;
  assign Fwd_Data   = head_result_q;
  assign Dbg_State  = state_q;

endmodule

// File: tb/tb_ex_result_stage.sv
// Bench for ex_result_stage: directed scenarios plus random traffic, checked
// against a FIFO-of-two reference model with an expected-entry queue.
module tb_ex_result_stage;
  import ex_result_pkg::*;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int W    = XLEN + RW + 1;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      f3;
  logic [RW-1:0]   rd;
  logic            reg_wr;
  logic [XLEN-1:0] add_r, set_r, log_r, sh_r;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [RW-1:0]   out_rd;
  logic            out_reg_wr;
  logic            fwd_valid;
  logic [RW-1:0]   fwd_rd;
  logic [XLEN-1:0] fwd_data;
  ex_state_e       dbg_state;

  // Entry packing: {reg_wr, rd, result}
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  ex_result_stage #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .CLK        (clk),
    .rst_n      (rst_n),
    .Flush      (flush),
    .In_Valid   (in_valid),
    .In_Ready   (in_ready),
    .Funct3     (f3),
    .Rd_Addr    (rd),
    .Reg_Wr     (reg_wr),
    .Add_Res    (add_r),
    .Set_Res    (set_r),
    .Logic_Res  (log_r),
    .Shift_Res  (sh_r),
    .Out_Valid  (out_valid),
    .Out_Ready  (out_ready),
    .Out_Result (out_result),
    .Out_Rd     (out_rd),
    .Out_Reg_Wr (out_reg_wr),
    .Fwd_Valid  (fwd_valid),
    .Fwd_Rd     (fwd_rd),
    .Fwd_Data   (fwd_data),
    .Dbg_State  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] ref_result();
    logic [XLEN-1:0] r;
    if (f3 == 3'd0)                  r = add_r;
    else if (f3 == 3'd1 || f3 == 3'd5) r = sh_r;
    else if (f3 == 3'd2 || f3 == 3'd3) begin
      r = '0;
      r[0] = set_r[0];
    end else                         r = log_r;
    return r;
  endfunction

  // Reference model: a two-deep FIFO; ready whenever fewer than two entries.
  task automatic model_update();
    bit acc, pp;
    logic wr_eff;
    acc = in_valid && (exp_q.size() < 2);
    pp  = (exp_q.size() > 0) && out_ready;
    wr_eff = reg_wr && (rd != 0);
    if (flush) begin
      exp_q.delete();
    end else begin
      if (pp) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({wr_eff, rd, ref_result()});
    end
  endtask

  task automatic check_outputs();
    logic [W-1:0] head;
    check("out_valid", out_valid, exp_q.size() > 0);
    check("in_ready", in_ready, exp_q.size() < 2);
    if (exp_q.size() > 0) begin
      head = exp_q[0];
      check("out_result", out_result, head[XLEN-1:0]);
      check("out_rd", out_rd, head[XLEN+RW-1:XLEN]);
      check("out_reg_wr", out_reg_wr, head[W-1]);
      check("fwd_valid", fwd_valid, head[W-1]);
      check("fwd_rd", fwd_rd, head[XLEN+RW-1:XLEN]);
      check("fwd_data", fwd_data, head[XLEN-1:0]);
    end else begin
      check("fwd_valid_empty", fwd_valid, 1'b0);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_op(input logic v, input logic [2:0] f, input logic [RW-1:0] r,
                        input logic w, input logic [XLEN-1:0] a, input logic [XLEN-1:0] s,
                        input logic [XLEN-1:0] l, input logic [XLEN-1:0] h);
    in_valid = v; f3 = f; rd = r; reg_wr = w;
    add_r = a; set_r = s; log_r = l; sh_r = h;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_out_result"}, out_result, '0);
    check({tag, "_out_rd"}, out_rd, '0);
    check({tag, "_out_reg_wr"}, out_reg_wr, 1'b0);
    check({tag, "_fwd_valid"}, fwd_valid, 1'b0);
    check({tag, "_fwd_rd"}, fwd_rd, '0);
    check({tag, "_fwd_data"}, fwd_data, '0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    set_op(0, 3'd0, '0, 0, '0, '0, '0, '0);
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Set-unit masking and forwarding
    out_ready = 1'b1;
    set_op(1, 3'b010, 5'd5, 1, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0);
    tick();
    check("slt_result", out_result, 32'h1);
    check("slt_fwd_valid", fwd_valid, 1'b1);
    check("slt_fwd_rd", fwd_rd, 5'd5);
    in_valid = 1'b0;
    tick();

    // Back-to-back adds at full throughput
    for (int i = 1; i <= 3; i++) begin
      set_op(1, 3'b000, 5'd7, 1, 32'h10 * i, 32'h0, 32'h0, 32'h0);
      tick();
      check("b2b_in_ready", in_ready, 1'b1);
    end
    in_valid = 1'b0;
    tick();

    // MEM stall: A and B fill the buffer, C is held upstream
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      set_op(1, 3'b000, 5'd3, 1, i, 32'h0, 32'h0, 32'h0);
      tick();
    end
    check("stall_in_ready_low", in_ready, 1'b0);
    check("stall_head_a", out_result, 32'h1);
    out_ready = 1'b1;
    tick();
    check("stall_head_b", out_result, 32'h2);
    tick();
    check("stall_head_c", out_result, 32'h3);
    in_valid = 1'b0;
    tick();
    tick();

    // Flush while full, with a same-cycle op that must be dropped
    out_ready = 1'b0;
    set_op(1, 3'b110, 5'd9, 1, 32'h0, 32'h0, 32'hAAAA_0001, 32'h0);
    tick();
    set_op(1, 3'b110, 5'd9, 1, 32'h0, 32'h0, 32'hAAAA_0002, 32'h0);
    tick();
    flush = 1'b1;
    set_op(1, 3'b110, 5'd9, 1, 32'h0, 32'h0, 32'hAAAA_0003, 32'h0);
    tick();
    flush = 1'b0;
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    set_op(1, 3'b001, 5'd10, 1, 32'h0, 32'h0, 32'h0, 32'h1234_5678);
    tick();
    check("post_flush_result", out_result, 32'h1234_5678);
    in_valid = 1'b0;
    tick();

    // Destination x0
    set_op(1, 3'b100, 5'd0, 1, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0);
    tick();
    check("x0_reg_wr", out_reg_wr, 1'b0);
    check("x0_fwd_valid", fwd_valid, 1'b0);
    check("x0_result", out_result, 32'hDEAD_BEEF);
    in_valid = 1'b0;
    tick();

    // Asynchronous reset while full
    out_ready = 1'b0;
    set_op(1, 3'b000, 5'd4, 1, 32'h55, 32'h0, 32'h0, 32'h0);
    tick();
    set_op(1, 3'b000, 5'd4, 1, 32'h66, 32'h0, 32'h0, 32'h0);
    tick();
    in_valid = 1'b0;
    check("pre_areset_full", in_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("areset");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic
    for (int c = 0; c < 2000; c++) begin
      set_op($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), RW'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      tick();
    end

    set_op(0, 3'd0, '0, 0, '0, '0, '0, '0);
    flush = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_result_stage.md
Name: ex_result_stage

Overview:
- Execute-stage back end: selects the result of the ALU sub-unit named by Funct3 (adder/subtractor, set unit, logic unit, shifter) and registers it into the EX/MEM boundary.
- Provides a 2-entry skid buffer with valid/ready handshakes on both sides, so a MEM-side stall never drops an ALU result.
- Exposes the head entry as a forwarding source for the decode/operand-select logic.

Parameters:
- XLEN, 32, datapath width
- REG_ADDR_W, 5, destination register index width

Ports:
- CLK  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- Flush  input  1  pipeline flush (branch/jump redirect)
- In_Valid  input  1  EX operation valid this cycle
- In_Ready  output  1  stage can accept an operation
- Funct3  input  3  instruction funct3; selects result source
- Rd_Addr  input  REG_ADDR_W  destination register index
- Reg_Wr  input  1  instruction writes Rd
- Add_Res  input  XLEN  adder/subtractor result
- Set_Res  input  XLEN  set-unit result (SLT/SLTU, bit 0 only meaningful)
- Logic_Res  input  XLEN  AND/OR/XOR result
- Shift_Res  input  XLEN  SLL/SRL/SRA result
- Out_Valid  output  1  head entry valid toward MEM
- Out_Ready  input  1  MEM accepts head entry
- Out_Result  output  XLEN  head entry result
- Out_Rd  output  REG_ADDR_W  head entry destination
- Out_Reg_Wr  output  1  head entry write enable
- Fwd_Valid  output  1  head entry valid, Reg_Wr set, and Rd nonzero
- Fwd_Rd  output  REG_ADDR_W  equals Out_Rd
- Fwd_Data  output  XLEN  equals Out_Result

Behaviour:
- Clock and reset: one clock, CLK; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0 except In_Ready=1. Internal state EMPTY; both entries cleared.
- Result select (combinational, before capture):
  - Funct3 000: Add_Res
  - 001 or 101: Shift_Res
  - 010 or 011: Set_Res with bits [XLEN-1:1] forced to 0
  - 100, 110 or 111: Logic_Res
- Write-enable rule: captured Reg_Wr is forced to 0 when Rd_Addr==0, so x0 is never written or forwarded.
- Storage: a head entry (drives the Out_* ports) and a skid entry.
- States:
  - EMPTY: no valid entry.
  - ONE: head valid, skid empty.
  - TWO: head and skid valid.
- Handshake events:
  - accept = In_Valid & In_Ready
  - pop = Out_Valid & Out_Ready
- In_Ready is registered: 1 exactly when the state is not TWO.
- Transitions (when Flush=0):
  - EMPTY, accept: data loads into head; go to ONE.
  - ONE, accept and pop together: head loads new data; stay in ONE.
  - ONE, accept without pop: data loads into skid; go to TWO.
  - ONE, pop without accept: go to EMPTY.
  - TWO, pop: skid moves to head; go to ONE. No accept is possible in TWO.
- Latency: 1 cycle from accept to Out_Valid when the stage is empty. Throughput is 1 op per cycle while Out_Ready=1.
- Ordering: strictly FIFO; the skid entry never overtakes the head.
- Flush has highest priority:
  - Next edge: state goes to EMPTY, Out_Valid=0, In_Ready=1.
  - Any same-cycle accept is discarded.
  - A same-cycle pop still completes from MEM's view, because Out_* are stable during that cycle.
- Out_Valid stability: once asserted, Out_Valid and Out_* must hold stable until pop or Flush.
- Reset mid-operation: asynchronous clear to the reset values, regardless of the handshakes.
- Fwd_* are purely combinational from the head entry, with no added latency.
- Width rules: no arithmetic is done in this block; sources are passed through at XLEN bits.

Decomposition:
- Shared package: Funct3 encodings (F3_ADD, F3_SLL, F3_SLT, F3_SLTU, F3_XOR, F3_SRL, F3_OR, F3_AND), the state encoding (EMPTY/ONE/TWO) and the XLEN default.
- One natural sub-module, ex_result_mux, holding the combinational Funct3 source select and the set-bit masking. The skid/state logic stays in ex_result_stage.

Test Plan:
- Reset, then Funct3=010, Set_Res=0xFFFFFFFF, Rd=5, Reg_Wr=1, Out_Ready=1 → the next cycle shows Out_Valid=1, Out_Result=0x00000001, Fwd_Valid=1, Fwd_Rd=5.
- Back-to-back adds 0x10, 0x20, 0x30 with Out_Ready=1 → outputs appear on consecutive cycles in order; In_Ready stays 1 throughout.
- Out_Ready=0, three In_Valid ops (A=0x1, B=0x2, C=0x3) → A and B accepted, In_Ready drops after B, and C is held upstream. Raising Out_Ready then yields A, B, C in order with no loss.
- State TWO with Flush=1 and Out_Ready=0 → the next cycle shows Out_Valid=0 and In_Ready=1; later ops emerge normally and no stale data appears.
- Rd_Addr=0, Reg_Wr=1, Logic_Res=0xDEADBEEF → Out_Reg_Wr=0, Fwd_Valid=0, Out_Result=0xDEADBEEF.
- rst_n asserted low mid-cycle while in TWO → outputs clear immediately without waiting for a clock edge; In_Ready=1.
